// File: rtl/grad_dac_serialiser.sv
// grad_dac_serialiser: shifts 32-bit gradient words MSB-first to up to four SPI DACs
// (shared SCLK, CPOL=0, per-lane SDO and CS_N). Reports busy and dropped-word status.
// Optional: define GRAD_DAC_SDI_CAPTURE_EN to add an SDI read-back path
// (sdi_i, rdata_o, rdata_valid_o) captured on every SCLK rising edge of a frame.
module grad_dac_serialiser #(
    parameter int unsigned NLANES = 4,
    parameter int unsigned WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] data_i,
    input  logic [NLANES-1:0] valid_i,
    input  logic [5:0]        spi_clk_div_i,
`ifdef GRAD_DAC_SDI_CAPTURE_EN
    input  logic              sdi_i,
    output logic [WORD_W-1:0] rdata_o,
    output logic              rdata_valid_o,
`endif
    output logic              sclk_o,
    output logic [NLANES-1:0] cs_n_o,
    output logic [NLANES-1:0] sdo_o,
    output logic              busy_o,
    output logic              data_lost_o
);

    localparam int unsigned DIV_W  = 6;
    localparam int unsigned BCNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        GAP   = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [DIV_W-1:0]    hcnt_q, hcnt_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic                phase_q, phase_d;      // 1 = SCLK high half of the current bit
    logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
    logic [WORD_W-1:0]   shreg_q, shreg_d;
    logic [NLANES-1:0]   mask_q, mask_d;

    logic                sclk_q, sclk_d;
    logic [NLANES-1:0]   cs_n_q, cs_n_d;
    logic [NLANES-1:0]   sdo_q, sdo_d;
    logic                busy_q, busy_d;
    logic                lost_q, lost_d;

    logic                half_done;
    logic                word_req;

    assign half_done = (hcnt_q == div_q);
    assign word_req  = |valid_i;

    // State register and datapath flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            hcnt_q  <= '0;
            div_q   <= '0;
            phase_q <= 1'b0;
            bcnt_q  <= '0;
            shreg_q <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            div_q   <= div_d;
            phase_q <= phase_d;
            bcnt_q  <= bcnt_d;
            shreg_q <= shreg_d;
            mask_q  <= mask_d;
        end
    end

    // Next-state logic: half-period timing, bit counting and shifting
    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        div_d   = div_q;
        phase_d = phase_q;
        bcnt_d  = bcnt_q;
        shreg_d = shreg_q;
        mask_d  = mask_q;

        unique case (state_q)
            IDLE: begin
                if (word_req) begin
                    state_d = SETUP;
                    hcnt_d  = '0;
                    div_d   = spi_clk_div_i;
                    shreg_d = data_i;
                    mask_d  = valid_i;
                    phase_d = 1'b0;
                    bcnt_d  = '0;
                end
            end
            SETUP: begin
                if (half_done) begin
                    state_d = SHIFT;
                    hcnt_d  = '0;
                    phase_d = 1'b1;
                    bcnt_d  = '0;
                end else begin
                    hcnt_d = DIV_W'(hcnt_q + DIV_W'(1));
                end
            end
            SHIFT: begin
                if (!half_done) begin
                    hcnt_d = DIV_W'(hcnt_q + DIV_W'(1));
                end else if (phase_q) begin
                    // Falling SCLK: present the next bit for the following rising edge
                    hcnt_d  = '0;
                    phase_d = 1'b0;
                    shreg_d = {shreg_q[WORD_W-2:0], 1'b0};
                end else if (bcnt_q == BCNT_W'(WORD_W - 1)) begin
                    state_d = GAP;
                    hcnt_d  = '0;
                end else begin
                    hcnt_d  = '0;
                    phase_d = 1'b1;
                    bcnt_d  = BCNT_W'(bcnt_q + BCNT_W'(1));
                end
            end
            GAP: begin
                if (half_done) begin
                    state_d = IDLE;
                    hcnt_d  = '0;
                end else begin
                    hcnt_d = DIV_W'(hcnt_q + DIV_W'(1));
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so every pin is a flop
    always_comb begin
        sclk_d = 1'b0;
        cs_n_d = '1;
        sdo_d  = '0;
        busy_d = (state_d != IDLE);
        lost_d = word_req && (state_q != IDLE);

        if (state_d == SETUP || state_d == SHIFT) begin
            cs_n_d = ~mask_d;
            sdo_d  = mask_d & {NLANES{shreg_d[WORD_W-1]}};
        end
        if (state_d == SHIFT) begin
            sclk_d = phase_d;
        end
    end

    // Output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_q <= 1'b0;
            cs_n_q <= '1;
            sdo_q  <= '0;
            busy_q <= 1'b0;
            lost_q <= 1'b0;
        end else begin
            sclk_q <= sclk_d;
            cs_n_q <= cs_n_d;
            sdo_q  <= sdo_d;
            busy_q <= busy_d;
            lost_q <= lost_d;
        end
    end

    assign sclk_o      = sclk_q;
    assign cs_n_o      = cs_n_q;
    assign sdo_o       = sdo_q;
    assign busy_o      = busy_q;
    assign data_lost_o = lost_q;

`ifdef GRAD_DAC_SDI_CAPTURE_EN
    logic [WORD_W-1:0] cap_q, cap_d;
    logic [WORD_W-1:0] rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;

    // SDI capture: sample on each SCLK rising edge, publish the word on GAP entry
    always_comb begin
        cap_d    = cap_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        if (sclk_d && !sclk_q) begin
            cap_d = {cap_q[WORD_W-2:0], sdi_i};
        end
        if (state_d == GAP && state_q != GAP) begin
            rdata_d  = cap_q;
            rvalid_d = 1'b1;
        end
    end

    // Read-back registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            cap_q    <= cap_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign rdata_o       = rdata_q;
    assign rdata_valid_o = rvalid_q;
`endif

endmodule

// File: tb/tb_grad_dac_serialiser.sv
// Bench for grad_dac_serialiser: directed and random frames checked against a
// cycle-indexed waveform model derived from the frame timing rules.
module tb_grad_dac_serialiser;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data_i;
    logic [3:0]  valid_i;
    logic [5:0]  spi_clk_div_i;
    logic        sclk_o;
    logic [3:0]  cs_n_o;
    logic [3:0]  sdo_o;
    logic        busy_o;
    logic        data_lost_o;
`ifdef GRAD_DAC_SDI_CAPTURE_EN
    logic        sdi_i;
    logic [31:0] rdata_o;
    logic        rdata_valid_o;
    assign sdi_i = sdo_o[0];
`endif

    int checks   = 0;
    int failures = 0;

    grad_dac_serialiser dut (
        .clk           (clk),
        .rst           (rst),
        .data_i        (data_i),
        .valid_i       (valid_i),
        .spi_clk_div_i (spi_clk_div_i),
`ifdef GRAD_DAC_SDI_CAPTURE_EN
        .sdi_i         (sdi_i),
        .rdata_o       (rdata_o),
        .rdata_valid_o (rdata_valid_o),
`endif
        .sclk_o        (sclk_o),
        .cs_n_o        (cs_n_o),
        .sdo_o         (sdo_o),
        .busy_o        (busy_o),
        .data_lost_o   (data_lost_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic idle_outputs_ok();
        return (sclk_o === 1'b0) && (cs_n_o === 4'hF) && (sdo_o === 4'h0) &&
               (busy_o === 1'b0) && (data_lost_o === 1'b0);
    endfunction

    // One frame: accept d/m at div, optionally inject a late strobe after sample lost_at
    // and change the divider after sample div_mid_at. Ends one cycle after busy falls.
    task automatic run_frame(input logic [31:0] d, input logic [3:0] m, input int div,
                             input int lost_at, input int div_mid_at, input int div_new,
                             input string tag);
        int          h, total, s, j, bi;
        logic        e_sclk, e_busy, e_lost, bitv, prev_sclk;
        logic [3:0]  e_cs, e_sdo;
        logic [31:0] rx [4];
        int          wave_err, rises, busy_cnt, lost_cnt, rv_cnt;
        h = div + 1;
        total = 66 * h;
        wave_err = 0; rises = 0; busy_cnt = 0; lost_cnt = 0; rv_cnt = 0;
        prev_sclk = 1'b0;
        for (int k = 0; k < 4; k++) rx[k] = '0;
        spi_clk_div_i = 6'(div);
        data_i  = d;
        valid_i = m;
        for (int t = 1; t <= total + 1; t++) begin
            @(posedge clk); #1;
            s = (t - 1) / h;
            e_sclk = 1'b0; e_cs = 4'hF; e_sdo = 4'h0; e_busy = (t <= total);
            if (t <= total && s == 0) begin
                e_cs = ~m;
                e_sdo = d[31] ? m : 4'h0;
            end else if (t <= total && s <= 64) begin
                j = s - 1;
                bi = j / 2;
                e_cs = ~m;
                e_sclk = (j % 2 == 0);
                if (e_sclk) bitv = d[31 - bi];
                else        bitv = (bi == 31) ? 1'b0 : d[30 - bi];
                e_sdo = bitv ? m : 4'h0;
            end
            e_lost = (lost_at > 0) && (t == lost_at + 1);
            if (sclk_o !== e_sclk || cs_n_o !== e_cs || sdo_o !== e_sdo ||
                busy_o !== e_busy || data_lost_o !== e_lost) wave_err++;
            if (sclk_o === 1'b1 && prev_sclk === 1'b0) begin
                rises++;
                for (int k = 0; k < 4; k++) rx[k] = {rx[k][30:0], sdo_o[k]};
            end
            prev_sclk = sclk_o;
            if (busy_o === 1'b1) busy_cnt++;
            if (data_lost_o === 1'b1) lost_cnt++;
`ifdef GRAD_DAC_SDI_CAPTURE_EN
            if (rdata_valid_o === 1'b1) begin
                rv_cnt++;
                if (t != 65 * h + 1) wave_err++;
            end
`endif
            // Stimulus for the next edge
            data_i  = $urandom;
            valid_i = (t == lost_at) ? 4'($urandom_range(1, 15)) : 4'h0;
            if (t == div_mid_at) spi_clk_div_i = 6'(div_new);
        end
        check({tag, ".wave"}, 64'(wave_err), 64'd0);
        check({tag, ".rises"}, 64'(rises), 64'd32);
        check({tag, ".busy_cycles"}, 64'(busy_cnt), 64'(total));
        check({tag, ".lost_pulses"}, 64'(lost_cnt), (lost_at > 0) ? 64'd1 : 64'd0);
        for (int k = 0; k < 4; k++)
            if (m[k]) check($sformatf("%s.lane%0d_word", tag, k), 64'(rx[k]), 64'(d));
`ifdef GRAD_DAC_SDI_CAPTURE_EN
        check({tag, ".rvalid_pulses"}, 64'(rv_cnt), 64'd1);
        if (m[0]) check({tag, ".rdata"}, 64'(rdata_o), 64'(d));
`endif
    endtask

    initial begin
        int idle_bad;
        int div_r, tot_r, lost_r;
        logic [31:0] d_r;
        rst = 1'b1;
        data_i = '0;
        valid_i = '0;
        spi_clk_div_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.outputs", 64'(idle_outputs_ok()), 64'd1);
`ifdef GRAD_DAC_SDI_CAPTURE_EN
        check("reset.rdata", 64'(rdata_o), 64'd0);
`endif
        rst = 1'b0;

        // Idle with no strobe: outputs stay quiet
        idle_bad = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (!idle_outputs_ok()) idle_bad++;
        end
        check("idle20", 64'(idle_bad), 64'd0);

        run_frame(32'hCAFEBEEF, 4'b1111, 1, 0, 0, 0, "cafe_div1");
        run_frame(32'h00A55A00, 4'b0101, 0, 0, 0, 0, "mask0101_div0");
        // Late strobe at cycle 50, then a word exactly at minimum pitch
        run_frame($urandom, 4'b1111, 3, 50, 0, 0, "lost50_div3");
        run_frame($urandom, 4'b1011, 3, 0, 0, 0, "min_pitch_div3");
        // Divider change mid-frame takes effect only on the next word
        run_frame($urandom, 4'b1111, 2, 0, 30, 9, "divchg_div2");
        run_frame($urandom, 4'b0110, 9, 0, 0, 0, "div9");

        // Reset mid-frame at bit 10: outputs drop immediately
        spi_clk_div_i = 6'd1;
        data_i = $urandom;
        valid_i = 4'hF;
        for (int t = 1; t <= 2 + 20 * 2 + 1; t++) begin
            @(posedge clk); #1;
            valid_i = 4'h0;
        end
        check("pre_abort.busy", 64'(busy_o), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("abort.outputs", 64'(idle_outputs_ok()), 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        idle_bad = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (!idle_outputs_ok()) idle_bad++;
        end
        check("abort.no_resume", 64'(idle_bad), 64'd0);
        run_frame(32'h12345678, 4'b1111, 1, 0, 0, 0, "post_abort");

        // Random frames, some with a dropped strobe anywhere in the frame
        for (int n = 0; n < 6; n++) begin
            div_r = $urandom_range(0, 3);
            tot_r = 66 * (div_r + 1);
            lost_r = ($urandom_range(0, 1) == 1) ? $urandom_range(1, tot_r) : 0;
            d_r = $urandom;
            run_frame(d_r, 4'($urandom_range(1, 15)), div_r, lost_r, 0, 0,
                      $sformatf("rand%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog against a wedged run
    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
